// File: rtl/foc_pwm_dt_nch.sv
// foc_pwm_dt_nch
//   Multi-channel complementary PWM generator. It has runtime dead time,
//   shadowed compare registers and a latched brake. All bridge legs share
//   one carrier counter. Compare and dead-time updates move from the shadow
//   registers to the active registers only at the carrier boundary.
//
// Ports
//   clk, rstn       : clock, asynchronous active-low reset
//   cnt, cnt_zero   : carrier count and one-cycle period-boundary strobe
//   comp1, comp2    : per-channel compare pairs, channel i at [i*PWM_WIDTH +: PWM_WIDTH]
//   dead_time       : requested dead time in clk cycles
//   load, load_ack  : shadow capture request / pulse on transfer to active
//   brake, brake_clr: fault input (active high) / clear of the latched fault
//   fault           : latched brake status
//   PWM_H, PWM_L    : high-side / low-side gate pins
module foc_pwm_dt_nch #(
  parameter int unsigned PWM_WIDTH         = 16,
  parameter int unsigned CH_NUM            = 3,
  parameter int unsigned DT_WIDTH          = 10,
  parameter int unsigned DEAT_TIME_RST     = 100,
  parameter logic        PWMH_ACTIVE_LEVEL = 1'b1,
  parameter logic        PWML_ACTIVE_LEVEL = 1'b1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [PWM_WIDTH-1:0]        cnt,
  input  logic                        cnt_zero,
  input  logic [CH_NUM*PWM_WIDTH-1:0] comp1,
  input  logic [CH_NUM*PWM_WIDTH-1:0] comp2,
  input  logic [DT_WIDTH-1:0]         dead_time,
  input  logic                        load,
  output logic                        load_ack,
  input  logic                        brake,
  input  logic                        brake_clr,
  output logic                        fault,
  output logic [CH_NUM-1:0]           PWM_H,
  output logic [CH_NUM-1:0]           PWM_L
);

  localparam int unsigned CW = CH_NUM * PWM_WIDTH;

  typedef enum logic [1:0] {
    HOLD_L   = 2'd0,
    HOLD_H   = 2'd1,
    CHANGE_H = 2'd2,
    CHANGE_L = 2'd3
  } state_t;

  logic [CW-1:0]       sh_c1, sh_c2, c1_act, c2_act;
  logic [DT_WIDTH-1:0] sh_dt, dt_act;
  logic                pending;
  logic [CH_NUM-1:0]   req, h_reg, l_reg;
  state_t              state [CH_NUM];
  logic [DT_WIDTH-1:0] dcnt  [CH_NUM];

  // The dead-time gap is finished once dcnt has reached dt_act-1. The compare is
  // done one bit wider so that dt_act==0 does not underflow and a dt_act that
  // shrinks below dcnt ends the gap on the next cycle.
  function automatic logic dt_reached(input logic [DT_WIDTH-1:0] d,
                                      input logic [DT_WIDTH-1:0] dt);
    return ({1'b0, d} + (DT_WIDTH+1)'(1)) >= {1'b0, dt};
  endfunction

  // Shadow capture and the transfer to active at the carrier boundary.
  // A load in the cnt_zero cycle bypasses the shadow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_c1    <= '0;
      sh_c2    <= '0;
      sh_dt    <= '0;
      c1_act   <= '0;
      c2_act   <= '0;
      dt_act   <= DT_WIDTH'(DEAT_TIME_RST);
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (load) begin
        sh_c1 <= comp1;
        sh_c2 <= comp2;
        sh_dt <= dead_time;
      end
      if (cnt_zero && (load || pending)) begin
        c1_act   <= load ? comp1 : sh_c1;
        c2_act   <= load ? comp2 : sh_c2;
        dt_act   <= load ? dead_time : sh_dt;
        pending  <= 1'b0;
        load_ack <= 1'b1;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Per-channel demand: 1 = high side, 0 = low side.
  always_comb begin
    req = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      req[i] = (cnt <= c1_act[i*PWM_WIDTH +: PWM_WIDTH]) ^
               (cnt <= c2_act[i*PWM_WIDTH +: PWM_WIDTH]);
    end
  end

  // Latched brake. A clear is ignored while brake is still asserted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          fault <= 1'b0;
    else if (brake)     fault <= 1'b1;
    else if (brake_clr) fault <= 1'b0;
  end

  // Dead-time FSM per leg. A brake or a fault parks the leg in CHANGE_L so
  // that the low side returns only after a full dead time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_reg <= '0;
      l_reg <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        state[i] <= CHANGE_L;
        dcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (fault || brake) begin
          state[i] <= CHANGE_L;
          dcnt[i]  <= '0;
          h_reg[i] <= 1'b0;
          l_reg[i] <= 1'b0;
        end else begin
          unique case (state[i])
            HOLD_L: if (req[i]) begin
              l_reg[i] <= 1'b0;
              if (dt_act == '0) begin
                state[i] <= HOLD_H;
                h_reg[i] <= 1'b1;
              end else begin
                state[i] <= CHANGE_H;
                dcnt[i]  <= '0;
              end
            end
            HOLD_H: if (!req[i]) begin
              h_reg[i] <= 1'b0;
              if (dt_act == '0) begin
                state[i] <= HOLD_L;
                l_reg[i] <= 1'b1;
              end else begin
                state[i] <= CHANGE_L;
                dcnt[i]  <= '0;
              end
            end
            CHANGE_H: begin
              if (!req[i]) begin
                state[i] <= HOLD_L;
                l_reg[i] <= 1'b1;
              end else if (dt_reached(dcnt[i], dt_act)) begin
                state[i] <= HOLD_H;
                h_reg[i] <= 1'b1;
              end else begin
                dcnt[i] <= dcnt[i] + DT_WIDTH'(1);
              end
            end
            CHANGE_L: begin
              if (req[i]) begin
                state[i] <= HOLD_H;
                h_reg[i] <= 1'b1;
              end else if (dt_reached(dcnt[i], dt_act)) begin
                state[i] <= HOLD_L;
                l_reg[i] <= 1'b1;
              end else begin
                dcnt[i] <= dcnt[i] + DT_WIDTH'(1);
              end
            end
            default: begin
              state[i] <= CHANGE_L;
              dcnt[i]  <= '0;
              h_reg[i] <= 1'b0;
              l_reg[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Pin drive. The brake masks the pins combinationally so that the fault
  // acts in the same cycle.
  always_comb begin
    PWM_H = '0;
    PWM_L = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      PWM_H[i] = (h_reg[i] && !brake && !fault) ? PWMH_ACTIVE_LEVEL : ~PWMH_ACTIVE_LEVEL;
      PWM_L[i] = (l_reg[i] && !brake && !fault) ? PWML_ACTIVE_LEVEL : ~PWML_ACTIVE_LEVEL;
    end
  end

endmodule

// File: tb/tb_foc_pwm_dt_nch.sv
// Directed bench for foc_pwm_dt_nch. It runs two instances from the same
// stimulus, one with active-high pins and one with active-low pins. An
// up-counting carrier 0..999 drives both. Per-period pin statistics are
// compared with hand-computed values.
module tb_foc_pwm_dt_nch;

  localparam int unsigned PW     = 16;
  localparam int unsigned CH     = 3;
  localparam int unsigned DW     = 10;
  localparam int unsigned PERIOD = 1000;

  logic              clk = 1'b0;
  logic              rstn;
  logic [PW-1:0]     cnt;
  logic              cnt_zero;
  logic [CH*PW-1:0]  comp1, comp2;
  logic [DW-1:0]     dead_time;
  logic              load, brake, brake_clr;
  logic              load_ack, fault, load_ack_n, fault_n;
  logic [CH-1:0]     pwm_h, pwm_l, pwm_h_n, pwm_l_n;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cval;
  int          h_cnt [CH];
  int          l_cnt [CH];
  int          off_cnt [CH];
  int          ovl_cnt [CH];
  int          hn_cnt [CH];
  int          ln_cnt [CH];
  int          run [CH];
  int          gap_min, gap_max;

  always #5 clk = ~clk;

  foc_pwm_dt_nch #(
    .PWM_WIDTH(PW), .CH_NUM(CH), .DT_WIDTH(DW), .DEAT_TIME_RST(100),
    .PWMH_ACTIVE_LEVEL(1'b1), .PWML_ACTIVE_LEVEL(1'b1)
  ) u_dut (
    .clk(clk), .rstn(rstn), .cnt(cnt), .cnt_zero(cnt_zero),
    .comp1(comp1), .comp2(comp2), .dead_time(dead_time), .load(load),
    .load_ack(load_ack), .brake(brake), .brake_clr(brake_clr), .fault(fault),
    .PWM_H(pwm_h), .PWM_L(pwm_l)
  );

  foc_pwm_dt_nch #(
    .PWM_WIDTH(PW), .CH_NUM(CH), .DT_WIDTH(DW), .DEAT_TIME_RST(100),
    .PWMH_ACTIVE_LEVEL(1'b0), .PWML_ACTIVE_LEVEL(1'b0)
  ) u_dut_n (
    .clk(clk), .rstn(rstn), .cnt(cnt), .cnt_zero(cnt_zero),
    .comp1(comp1), .comp2(comp2), .dead_time(dead_time), .load(load),
    .load_ack(load_ack_n), .brake(brake), .brake_clr(brake_clr), .fault(fault_n),
    .PWM_H(pwm_h_n), .PWM_L(pwm_l_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int unsigned a0, input int unsigned b0,
                         input int unsigned a1, input int unsigned b1,
                         input int unsigned a2, input int unsigned b2,
                         input int unsigned dt);
    comp1     = {PW'(a2), PW'(a1), PW'(a0)};
    comp2     = {PW'(b2), PW'(b1), PW'(b0)};
    dead_time = DW'(dt);
  endtask

  // Present the next carrier value for one cycle. Return 1 time unit after
  // the edge that consumed it.
  task automatic step();
    cnt      = PW'(cval);
    cnt_zero = (cval == 0);
    cval     = (cval == PERIOD - 1) ? 0 : cval + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int unsigned target);
    for (int k = 0; k < int'(PERIOD) && cval != target; k++) step();
  endtask

  task automatic measure(input int n);
    for (int i = 0; i < int'(CH); i++) begin
      h_cnt[i] = 0; l_cnt[i] = 0; off_cnt[i] = 0; ovl_cnt[i] = 0;
      hn_cnt[i] = 0; ln_cnt[i] = 0; run[i] = 0;
    end
    gap_min = 1 << 30;
    gap_max = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int i = 0; i < int'(CH); i++) begin
        if (pwm_h[i]) h_cnt[i]++;
        if (pwm_l[i]) l_cnt[i]++;
        if (pwm_h[i] && pwm_l[i]) ovl_cnt[i]++;
        if (!pwm_h_n[i]) hn_cnt[i]++;
        if (!pwm_l_n[i]) ln_cnt[i]++;
        if (!pwm_h[i] && !pwm_l[i]) begin
          off_cnt[i]++;
          run[i]++;
        end else if (run[i] != 0) begin
          if (run[i] < gap_min) gap_min = run[i];
          if (run[i] > gap_max) gap_max = run[i];
          run[i] = 0;
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0; cnt = '0; cnt_zero = 1'b0; load = 1'b0;
    brake = 1'b0; brake_clr = 1'b0; cval = 0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_fault",    32'(fault), 0);
    check("rst_ack",      32'(load_ack), 0);
    check("rst_h",        32'(pwm_h), 0);
    check("rst_l",        32'(pwm_l), 0);
    check("rst_h_inv",    32'(pwm_h_n), 7);
    check("rst_l_inv",    32'(pwm_l_n), 7);

    // Release reset: L stays off for 100 cycles and turns on afterwards
    rstn = 1'b1;
    repeat (99) step();
    check("rst_l_gap",    32'(pwm_l), 0);
    step();
    check("rst_l_on",     32'(pwm_l), 7);
    check("rst_l_on_inv", 32'(pwm_l_n), 0);
    check("rst_h_off",    32'(pwm_h), 0);

    // Dead time 20. Set up the channels and apply them through the shadow
    set_cfg(100, 300, 500, 900, 700, 750, 20);
    load = 1'b1; step(); load = 1'b0;
    check("dt_ack_wait",  32'(load_ack), 0);
    run_to(0);
    step();
    check("dt_ack",       32'(load_ack), 1);
    measure(PERIOD);
    check("dt_h0",        32'(h_cnt[0]), 180);
    check("dt_h1",        32'(h_cnt[1]), 380);
    check("dt_h2",        32'(h_cnt[2]), 30);
    check("dt_off0",      32'(off_cnt[0]), 40);
    check("dt_off1",      32'(off_cnt[1]), 40);
    check("dt_off2",      32'(off_cnt[2]), 40);
    check("dt_ovl",       32'(ovl_cnt[0] + ovl_cnt[1] + ovl_cnt[2]), 0);
    check("dt_gap_min",   32'(gap_min), 20);
    check("dt_gap_max",   32'(gap_max), 20);

    // Shadow: two loads mid-period. Only the last one applies, and only from the next period
    run_to(50);
    set_cfg(200, 300, 500, 900, 700, 750, 20);
    load = 1'b1; step(); load = 1'b0;
    check("sh_ack_early", 32'(load_ack), 0);
    set_cfg(250, 300, 500, 900, 700, 750, 20);
    load = 1'b1; step(); load = 1'b0;
    measure(PERIOD - 52);
    check("sh_old_h0",    32'(h_cnt[0]), 180);
    check("sh_ack_wait",  32'(load_ack), 0);
    step();
    check("sh_ack",       32'(load_ack), 1);
    step();
    check("sh_ack_pulse", 32'(load_ack), 0);
    measure(PERIOD - 1);
    check("sh_new_h0",    32'(h_cnt[0]), 30);
    check("sh_new_h1",    32'(h_cnt[1]), 380);

    // Short pulse, loaded in the cnt_zero cycle: demand reverts inside the gap
    run_to(0);
    set_cfg(295, 300, 500, 900, 700, 750, 20);
    load = 1'b1; step(); load = 1'b0;
    check("sp_direct_ack", 32'(load_ack), 1);
    measure(PERIOD - 1);
    check("sp_h0",        32'(h_cnt[0]), 0);
    check("sp_off0",      32'(off_cnt[0]), 5);
    check("sp_ovl0",      32'(ovl_cnt[0]), 0);

    // Zero dead time: direct swap, and the inverted instance mirrors it
    set_cfg(100, 300, 500, 900, 700, 750, 0);
    load = 1'b1; step(); load = 1'b0;
    measure(PERIOD - 1);
    check("z_h0",         32'(h_cnt[0]), 200);
    check("z_h1",         32'(h_cnt[1]), 400);
    check("z_h2",         32'(h_cnt[2]), 50);
    check("z_l0",         32'(l_cnt[0]), 799);
    check("z_off",        32'(off_cnt[0] + off_cnt[1] + off_cnt[2]), 0);
    check("z_ovl",        32'(ovl_cnt[0] + ovl_cnt[1] + ovl_cnt[2]), 0);
    check("z_h0_inv",     32'(hn_cnt[0]), 200);
    check("z_l0_inv",     32'(ln_cnt[0]), 799);

    // Brake mid-H with dead time 20
    set_cfg(100, 300, 500, 900, 700, 750, 20);
    load = 1'b1; step(); load = 1'b0;
    run_to(200);
    check("brk_pre_h0",   32'(pwm_h[0]), 1);
    brake = 1'b1;
    #1;
    check("brk_comb_h",   32'(pwm_h), 0);
    check("brk_comb_l",   32'(pwm_l), 0);
    check("brk_comb_inv", 32'(pwm_h_n), 7);
    step();
    brake = 1'b0;
    #1;
    check("brk_fault",    32'(fault), 1);
    repeat (10) step();
    check("brk_hold",     32'(pwm_h | pwm_l), 0);
    brake = 1'b1; brake_clr = 1'b1;
    step();
    brake = 1'b0; brake_clr = 1'b0;
    #1;
    check("brk_clr_ign",  32'(fault), 1);
    run_to(320);
    check("brk_hold2",    32'(pwm_h | pwm_l), 0);
    brake_clr = 1'b1; step(); brake_clr = 1'b0;
    check("brk_cleared",  32'(fault), 0);
    repeat (19) step();
    check("brk_l_gap",    32'(pwm_l), 0);
    step();
    check("brk_l_on",     32'(pwm_l), 7);
    check("brk_h_off",    32'(pwm_h), 0);

    // Asynchronous reset while H is on
    run_to(200);
    check("ar_pre_h0",    32'(pwm_h[0]), 1);
    rstn = 1'b0;
    #1;
    check("ar_h",         32'(pwm_h), 0);
    check("ar_l",         32'(pwm_l), 0);
    check("ar_h_inv",     32'(pwm_h_n), 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
